// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with stall, PS-driven next-PC select and a circular return-address stack.
// Optional build macro PC_ALIGN_CHECK_EN: aligns loaded targets down to INC and flags them via misaligned.
module program_counter_ras #(
  parameter int unsigned             WIDTH        = 64,
  parameter int unsigned             INC          = 4,
  parameter int unsigned             RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0]        RESET_VECTOR = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             en,
  input  logic [1:0]                       PS,
  input  logic [WIDTH-1:0]                 in,
  input  logic                             link,
  input  logic                             ret,
  output logic [WIDTH-1:0]                 PC,
  output logic [WIDTH-1:0]                 PC4,
  output logic [WIDTH-1:0]                 ras_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow,
  output logic                             misaligned
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             load;
  logic [WIDTH-1:0] raw_target;
  logic [WIDTH-1:0] next_pc;
  logic             next_mis;

  assign PC4     = PC + WIDTH'(INC);
  assign empty   = (ras_count == '0);
  assign full    = (ras_count == CW'(RAS_DEPTH));
  assign pop_ok  = ret && !empty;
  assign ras_top = empty ? '0 : stack[top];
  assign top_inc = (top == PW'(RAS_DEPTH - 1)) ? '0 : top + PW'(1);
  assign top_dec = (top == '0) ? PW'(RAS_DEPTH - 1) : top - PW'(1);

  // Next-PC select: a successful pop overrides PS; load marks externally supplied targets.
  always_comb begin
    raw_target = PC;
    load       = 1'b0;
    if (pop_ok) begin
      raw_target = stack[top];
      load       = 1'b1;
    end else begin
      case (PS)
        2'b00:   raw_target = PC;
        2'b01:   raw_target = PC4;
        2'b10: begin
          raw_target = PC + in;
          load       = 1'b1;
        end
        default: begin
          raw_target = in;
          load       = 1'b1;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(INC) - WIDTH'(1);

  always_comb begin
    next_mis = load && ((raw_target & LOW_MASK) != '0);
    next_pc  = load ? (raw_target & ~LOW_MASK) : raw_target;
  end
`else
  always_comb begin
    next_mis = 1'b0;
    next_pc  = raw_target;
  end

  logic unused_load;
  assign unused_load = load;
`endif

  // PC, stack and sticky flags; stall freezes everything including misaligned.
  always_ff @(posedge clock) begin
    if (reset) begin
      PC            <= RESET_VECTOR;
      top           <= '0;
      ras_count     <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      misaligned    <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (en) begin
      PC         <= next_pc;
      misaligned <= next_mis;
      if (ret && empty) begin
        ras_underflow <= 1'b1;
      end
      if (link && ret) begin
        // Jump used the old top; replace it in place, or start a fresh entry when empty.
        if (empty) begin
          top          <= top_inc;
          stack[top_inc] <= PC4;
          ras_count    <= CW'(1);
        end else begin
          stack[top] <= PC4;
        end
      end else if (link) begin
        top            <= top_inc;
        stack[top_inc] <= PC4;
        if (full) begin
          ras_overflow <= 1'b1;
        end else begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (pop_ok) begin
        top       <= top_dec;
        ras_count <= ras_count - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_counter_ras.sv
// Randomised and directed bench for program_counter_ras against a queue-based reference model.
// Build with PC_ALIGN_CHECK_EN defined on both files to exercise the alignment feature.
module tb_program_counter_ras;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned INC   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RV    = 64'h400;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  PS;
  logic [63:0] in;
  logic        link;
  logic        ret;
  logic [63:0] PC;
  logic [63:0] PC4;
  logic [63:0] ras_top;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC plus the stack as a queue (newest at the back).
  logic [63:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_ovf;
  bit          m_unf;
  bit          m_mis;

  program_counter_ras #(
    .WIDTH(WIDTH), .INC(INC), .RAS_DEPTH(DEPTH), .RESET_VECTOR(RV)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .PS(PS), .in(in), .link(link), .ret(ret),
    .PC(PC), .PC4(PC4), .ras_top(ras_top), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow), .misaligned(misaligned)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] m_top();
    if (m_q.size() == 0) return 64'h0;
    return m_q[m_q.size() - 1];
  endfunction

  function automatic logic [133:0] m_stat();
    return {m_pc + 64'(INC), m_top(), 3'(m_q.size()), m_ovf, m_unf, m_mis};
  endfunction

  function automatic logic [133:0] dut_stat();
    return {PC4, ras_top, ras_count, ras_overflow, ras_underflow, misaligned};
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [1:0] ps,
                            input logic [63:0] d, input logic lk, input logic rt);
    logic [63:0] tgt;
    logic [63:0] pc4;
    bit          ld;
    if (r) begin
      m_pc = RV; m_q.delete(); m_ovf = 0; m_unf = 0; m_mis = 0;
      return;
    end
    if (!e) return;
    pc4 = m_pc + 64'(INC);
    ld  = 0;
    if (rt && m_q.size() > 0) begin
      tgt = m_top(); ld = 1;
    end else begin
      case (ps)
        2'd0: tgt = m_pc;
        2'd1: tgt = pc4;
        2'd2: begin tgt = m_pc + d; ld = 1; end
        default: begin tgt = d; ld = 1; end
      endcase
      if (rt) m_unf = 1;
    end
    if (lk && rt) begin
      if (m_q.size() > 0) m_q[m_q.size() - 1] = pc4;
      else m_q.push_back(pc4);
    end else if (lk) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(pc4);
    end else if (rt && m_q.size() > 0) begin
      void'(m_q.pop_back());
    end
    m_mis = 0;
    if (ALIGN_EN && ld && (tgt % INC) != 0) begin
      m_mis = 1;
      tgt   = tgt - (tgt % INC);
    end
    m_pc = tgt;
  endtask

  task automatic cycle(input logic r, input logic e, input logic [1:0] ps,
                       input logic [63:0] d, input logic lk, input logic rt);
    reset = r; en = e; PS = ps; in = d; link = lk; ret = rt;
    @(posedge clock);
    #1;
    model_step(r, e, ps, d, lk, rt);
  endtask

  task automatic test_reset();
    cycle(1, 1, 2'd3, 64'h1234, 1, 1);
    cycle(1, 0, 2'd1, 64'h0, 1, 0);
    checks++;
    if (PC !== 64'h400) begin
      errors++; $display("FAIL reset PC got %h exp %h", PC, 64'h400);
    end
    checks++;
    if (dut_stat() !== m_stat()) begin
      errors++; $display("FAIL reset status got %h exp %h", dut_stat(), m_stat());
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 2'd1, 64'h0, 0, 0);
      checks++;
      if (PC !== 64'h400 + 64'(4 * (i + 1))) begin
        errors++; $display("FAIL seq[%0d] PC got %h exp %h", i, PC, 64'h400 + 64'(4 * (i + 1)));
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL seq[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
  endtask

  task automatic test_branch_stall();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: cycle(0, 1, 2'd3, 64'h100, 0, 0);
        1: cycle(0, 1, 2'd2, 64'hFFFF_FFFF_FFFF_FFF0, 0, 0);
        2: cycle(0, 1, 2'd3, 64'h2000, 0, 0);
        default: cycle(0, 0, 2'd1, 64'h0, 1, 1);
      endcase
      checks++;
      if (PC !== m_pc) begin
        errors++; $display("FAIL branch[%0d] PC got %h exp %h", i, PC, m_pc);
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL branch[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
  endtask

  task automatic test_link_ret();
    cycle(1, 1, 2'd0, 64'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: cycle(0, 1, 2'd3, 64'h500, 0, 0);
        1: cycle(0, 1, 2'd3, 64'h900, 1, 0);
        default: cycle(0, 1, 2'd0, 64'h0, 0, 1);
      endcase
      checks++;
      if (PC !== m_pc) begin
        errors++; $display("FAIL linkret[%0d] PC got %h exp %h", i, PC, m_pc);
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL linkret[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
    checks++;
    if (PC !== 64'h504) begin
      errors++; $display("FAIL linkret_final PC got %h exp %h", PC, 64'h504);
    end
  endtask

  task automatic test_overflow();
    cycle(1, 1, 2'd0, 64'h0, 0, 0);
    cycle(0, 1, 2'd3, 64'h10, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 1, 2'd3, 64'(16 * (k + 1)), 1, 0);
    end
    checks++;
    if (dut_stat() !== m_stat()) begin
      errors++; $display("FAIL overflow status got %h exp %h", dut_stat(), m_stat());
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 2'd0, 64'h0, 0, 1);
      checks++;
      if (PC !== 64'h54 - 64'(16 * i)) begin
        errors++; $display("FAIL pop[%0d] PC got %h exp %h", i, PC, 64'h54 - 64'(16 * i));
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL pop[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
  endtask

  task automatic test_underflow_combo();
    cycle(1, 1, 2'd0, 64'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: cycle(0, 1, 2'd3, 64'h80, 0, 0);
        1: cycle(0, 1, 2'd1, 64'h0, 0, 1);
        2: cycle(0, 1, 2'd3, 64'h200, 1, 0);
        3: cycle(0, 1, 2'd3, 64'h300, 1, 0);
        default: cycle(0, 1, 2'd0, 64'h0, 1, 1);
      endcase
      checks++;
      if (PC !== m_pc) begin
        errors++; $display("FAIL underflow[%0d] PC got %h exp %h", i, PC, m_pc);
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL underflow[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
    checks++;
    if (PC !== 64'h204 || ras_top !== 64'h304 || ras_count !== 3'd2) begin
      errors++;
      $display("FAIL combo_final got PC %h top %h cnt %0d exp PC %h top %h cnt 2",
               PC, ras_top, ras_count, 64'h204, 64'h304);
    end
  endtask

  task automatic test_align_midreset();
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: cycle(0, 1, 2'd3, 64'h1003, 0, 0);
        1: cycle(0, 1, 2'd1, 64'h0, 0, 0);
        2, 3, 4: cycle(0, 1, 2'd3, 64'h1802 + 64'(16 * i), 1, 0);
        5: cycle(1, 1, 2'd3, 64'h77, 1, 1);
        default: cycle(0, 1, 2'd2, 64'h6, 0, 0);
      endcase
      checks++;
      if (PC !== m_pc) begin
        errors++; $display("FAIL align[%0d] PC got %h exp %h", i, PC, m_pc);
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL align[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  ps;
    logic [63:0] d;
    for (int i = 0; i < 400; i++) begin
      ps = 2'($urandom_range(0, 3));
      d  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($signed($urandom_range(0, 255)) - 128);
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0), ps, d,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
      checks++;
      if (PC !== m_pc) begin
        errors++; $display("FAIL random[%0d] PC got %h exp %h", i, PC, m_pc);
      end
      checks++;
      if (dut_stat() !== m_stat()) begin
        errors++; $display("FAIL random[%0d] status got %h exp %h", i, dut_stat(), m_stat());
      end
    end
  endtask

  initial begin
    m_pc = 64'h0; m_ovf = 0; m_unf = 0; m_mis = 0;
    reset = 1'b1; en = 1'b0; PS = 2'd0; in = 64'h0; link = 1'b0; ret = 1'b0;
    test_reset();
    test_sequential();
    test_branch_stall();
    test_link_ret();
    test_overflow();
    test_underflow_combo();
    test_align_midreset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
